goml_ctrl_bank: RTL and testbench
=================================

// Module: goml_ctrl_bank
// PURPOSE
//  Multi-lane, clocked successor of the goML go/error controller for timing-resilient pipeline stages.
//  Per lane, registers go from the error-detect flags (err0/err1) and the handshakes (rreq/reack), only on sample.
//  New: saturating per-lane error counter; timed RECOVER state after an error; aggregated error flag.
//  Sits between the stage error-detecting latches and the stage handshake controller.
// PARAMETERS
//  LANES      4  number of independent lanes (>=1)
//  CNT_W      8  width of each per-lane error counter (>=1)
//  RECOV_CYC  2  cycles a lane stays in RECOVER after its last sampled error (>=1)
// PORTS
//  clk      in   1            clock, rising edge
//  rst      in   1            reset, asynchronous, active-high
//  sample   in   LANES        per-lane sample strobe; go updates only when set (NORMAL)
//  err0     in   LANES        error flag 0 from stage error detector
//  err1     in   LANES        error flag 1 from stage error detector
//  rreq     in   LANES        request to recovery path
//  reack    in   LANES        acknowledge from normal (error-free) path
//  cnt_clr  in   1            synchronous clear of all error counters
//  go       out  LANES        registered go (goML) per lane
//  busy     out  LANES        lane is in RECOVER
//  err_cnt  out  LANES*CNT_W  lane i count at [i*CNT_W +: CNT_W], saturating
//  err_any  out  1            registered OR of all lanes' sampled errors from the previous cycle
// BEHAVIOUR
//  - Reset (async, rst=1): go=0, busy=0, err_cnt=0, err_any=0, all lanes NORMAL, timers 0.
//  - Sampled error e_i = sample_i & (err0_i | err1_i); err0&err1 together = one error.
//  - Lane FSM states: NORMAL, RECOVER. All outputs registered; 1-cycle latency.
//  - NORMAL, sample=0: go holds (hold term of goML).
//  - NORMAL, sample=1: go <= (err0|err1) ? rreq : reack.
//    On error: -> RECOVER, timer <= RECOV_CYC-1.
//  - RECOVER: go <= rreq every cycle, regardless of sample.
//    Sampled error: timer reloads to RECOV_CYC-1 and stays in RECOVER.
//    Else timer==0 -> NORMAL, else timer decrements.
//    busy = (state==RECOVER).
//  - Counter: +1 per sampled error in any state; holds at 2^CNT_W-1 (no wrap).
//    cnt_clr same cycle as an error -> clear wins, count=0.
//  - err_any <= |e (all lanes). Lanes fully independent; no cross-lane priority.
//  - rst asserted mid-RECOVER: immediate return to reset values; no residual timer state.
// CONFIGURATION
//  - Macro GOML_ERR_LOG_EN defined: adds port log_clr (in, 1) and err_log (out, LANES).
//    err_log: sticky bit per lane, set on sampled error, cleared by log_clr.
//    Set wins over simultaneous clear. Reset value 0.
//  - Not defined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  - Package goml_pkg: typedef enum lane_state_t {LS_NORMAL, LS_RECOVER};
//    function for timer width, $clog2(RECOV_CYC) min 1.
//  - Sub-module goml_lane: one lane (FSM, timer, counter, go reg).
//    Top instantiates LANES copies in a generate loop, plus the err_any OR and the optional err_log bank.
// TESTING
//  - Reset: rst=1 mid-stream -> all outputs 0 immediately (async); rst=0, no stimulus -> outputs stay 0.
//  - Normal path: lane0 sample=1, err=00, reack=1 -> go0=1 next cycle;
//    sample=0, reack=0 -> go0 stays 1.
//  - Error path: lane1 sample=1, err1=1, rreq=1 -> next cycle go1=1, busy1=1, err_cnt[1]=1, err_any=1;
//    with RECOV_CYC=2 and no more errors, busy1 falls after 2 cycles in RECOVER.
//  - Re-error: second sampled error while RECOVER (timer=0) -> timer reloads, busy held 2 more cycles, cnt=2.
//  - Saturation/clear: CNT_W=2, 5 errors -> cnt=3 and holds;
//    cnt_clr with a simultaneous error -> cnt=0.
//  - GOML_ERR_LOG_EN: error sets err_log, log_clr alone clears it, log_clr+error -> err_log stays 1.
//    Build without the macro also compiles and passes the other tests.

Source files
------------

// File: rtl/goml_pkg.sv
// Shared types and helpers for the goML go/error controller bank.
//   lane_state_t : per-lane FSM state encoding
//   timer_w()    : width of the RECOVER down-counter, never below 1 bit
package goml_pkg;

    typedef enum logic {
        LS_NORMAL  = 1'b0,
        LS_RECOVER = 1'b1
    } lane_state_t;

    // The timer only ever holds 0..recov_cyc-1.
    function automatic int timer_w(input int recov_cyc);
        int w;
        w = $clog2(recov_cyc);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/goml_lane.sv
// One goML lane: go register, NORMAL/RECOVER FSM with recovery timer, and a
// saturating error counter.
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   sample_i              sample strobe; go updates only when set (NORMAL)
//   err0_i, err1_i        error-detector flags
//   rreq_i, reack_i       recovery request / normal-path acknowledge
//   cnt_clr_i             synchronous counter clear (wins over an error)
//   go_o, busy_o          registered go, lane-in-RECOVER
//   err_cnt_o             saturating count of sampled errors
//   err_s_o               sampled error this cycle (combinational, for the bank)
//
// state      | meaning
// -----------+---------------------------------------------------------------
// LS_NORMAL  | go follows reack (or rreq on error) when sampled, else holds
// LS_RECOVER | go follows rreq every cycle; leaves when timer expires error-free
module goml_lane
    import goml_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int RECOV_CYC = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sample_i,
    input  logic             err0_i,
    input  logic             err1_i,
    input  logic             rreq_i,
    input  logic             reack_i,
    input  logic             cnt_clr_i,
    output logic             go_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             err_s_o
);

    localparam int              TW      = timer_w(RECOV_CYC);
    localparam logic [TW-1:0]   RELOAD  = TW'(RECOV_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    lane_state_t      state_q;
    logic [TW-1:0]    timer_q;
    logic             go_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_raw;
    logic             err_s;

    // Both flags together still count as a single error.
    assign err_raw = err0_i | err1_i;
    assign err_s   = sample_i & err_raw;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= LS_NORMAL;
            timer_q <= '0;
            go_q    <= 1'b0;
        end else begin
            case (state_q)
                LS_NORMAL: begin
                    if (sample_i) begin
                        go_q <= err_raw ? rreq_i : reack_i;
                        if (err_raw) begin
                            state_q <= LS_RECOVER;
                            timer_q <= RELOAD;
                        end
                    end
                end
                LS_RECOVER: begin
                    go_q <= rreq_i;
                    if (err_s) begin
                        timer_q <= RELOAD;
                    end else if (timer_q == '0) begin
                        state_q <= LS_NORMAL;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= LS_NORMAL;
                    timer_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (err_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign go_o      = go_q;
    assign busy_o    = (state_q == LS_RECOVER);
    assign err_cnt_o = cnt_q;
    assign err_s_o   = err_s;

endmodule

// File: rtl/goml_ctrl_bank.sv
// Multi-lane goML go/error controller bank. Sits between the stage
// error-detecting latches and the stage handshake controller.
// Ports:
//   clk_i, rst_i     clock, async active-high reset
//   sample_i, err0_i, err1_i, rreq_i, reack_i   per-lane inputs
//   cnt_clr_i        clears every lane's error counter
//   log_clr_i        (GOML_ERR_LOG_EN only) clears the sticky error log
//   go_o, busy_o     per-lane registered go / in-RECOVER
//   err_cnt_o        lane i count at [i*CNT_W +: CNT_W]
//   err_any_o        registered OR of all lanes' sampled errors
//   err_log_o        (GOML_ERR_LOG_EN only) sticky per-lane error bit
// Build option: define GOML_ERR_LOG_EN to add the sticky error log.
module goml_ctrl_bank
    import goml_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int CNT_W     = 8,
    parameter int RECOV_CYC = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [LANES-1:0]       sample_i,
    input  logic [LANES-1:0]       err0_i,
    input  logic [LANES-1:0]       err1_i,
    input  logic [LANES-1:0]       rreq_i,
    input  logic [LANES-1:0]       reack_i,
    input  logic                   cnt_clr_i,
`ifdef GOML_ERR_LOG_EN
    input  logic                   log_clr_i,
    output logic [LANES-1:0]       err_log_o,
`endif
    output logic [LANES-1:0]       go_o,
    output logic [LANES-1:0]       busy_o,
    output logic [LANES*CNT_W-1:0] err_cnt_o,
    output logic                   err_any_o
);

    logic [LANES-1:0] err_s;
    logic             err_any_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        goml_lane #(
            .CNT_W     (CNT_W),
            .RECOV_CYC (RECOV_CYC)
        ) u_lane (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .sample_i  (sample_i[g]),
            .err0_i    (err0_i[g]),
            .err1_i    (err1_i[g]),
            .rreq_i    (rreq_i[g]),
            .reack_i   (reack_i[g]),
            .cnt_clr_i (cnt_clr_i),
            .go_o      (go_o[g]),
            .busy_o    (busy_o[g]),
            .err_cnt_o (err_cnt_o[g*CNT_W +: CNT_W]),
            .err_s_o   (err_s[g])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_any_q <= 1'b0;
        end else begin
            err_any_q <= |err_s;
        end
    end

    assign err_any_o = err_any_q;

`ifdef GOML_ERR_LOG_EN
    logic [LANES-1:0] log_q, log_d;

    // A new error in the same cycle as a clear leaves the bit set.
    always_comb begin
        log_d = (log_q & ~{LANES{log_clr_i}}) | err_s;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            log_q <= '0;
        end else begin
            log_q <= log_d;
        end
    end

    assign err_log_o = log_q;
`endif

endmodule

// File: tb/tb_goml_ctrl_bank.sv
module tb_goml_ctrl_bank;

    localparam int LANES     = 4;
    localparam int CNT_W     = 2;
    localparam int RECOV_CYC = 2;
    localparam int CNT_SAT   = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [LANES-1:0]       sample, err0, err1, rreq, reack;
    logic                   cnt_clr;
    logic                   log_clr;
    logic [LANES-1:0]       go, busy, err_log;
    logic [LANES*CNT_W-1:0] err_cnt;
    logic                   err_any;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state, kept at the level of the behavioural rules.
    int m_left[LANES];   // cycles of RECOVER still to come (0 = NORMAL)
    bit m_go[LANES];
    int m_cnt[LANES];
    bit m_log[LANES];
    bit m_any;

    always #5 clk = ~clk;

    goml_ctrl_bank #(
        .LANES     (LANES),
        .CNT_W     (CNT_W),
        .RECOV_CYC (RECOV_CYC)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .sample_i  (sample),
        .err0_i    (err0),
        .err1_i    (err1),
        .rreq_i    (rreq),
        .reack_i   (reack),
        .cnt_clr_i (cnt_clr),
`ifdef GOML_ERR_LOG_EN
        .log_clr_i (log_clr),
        .err_log_o (err_log),
`endif
        .go_o      (go),
        .busy_o    (busy),
        .err_cnt_o (err_cnt),
        .err_any_o (err_any)
    );

`ifndef GOML_ERR_LOG_EN
    assign err_log = '0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) begin
            m_left[i] = 0;
            m_go[i]   = 1'b0;
            m_cnt[i]  = 0;
            m_log[i]  = 1'b0;
        end
        m_any = 1'b0;
    endtask

    task automatic model_clock();
        bit e;
        bit any;
        any = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            e = sample[i] & (err0[i] | err1[i]);
            any |= e;
            if (m_left[i] > 0)  m_go[i] = rreq[i];
            else if (sample[i]) m_go[i] = (err0[i] | err1[i]) ? rreq[i] : reack[i];
            if (e)                m_left[i] = RECOV_CYC;
            else if (m_left[i] > 0) m_left[i]--;
            if (cnt_clr)          m_cnt[i] = 0;
            else if (e && m_cnt[i] < CNT_SAT) m_cnt[i]++;
`ifdef GOML_ERR_LOG_EN
            if (e)            m_log[i] = 1'b1;
            else if (log_clr) m_log[i] = 1'b0;
`endif
        end
        m_any = any;
    endtask

    task automatic check_all(input string tag);
        logic [LANES-1:0]       eg, eb, el;
        logic [LANES*CNT_W-1:0] ec;
        for (int i = 0; i < LANES; i++) begin
            eg[i] = m_go[i];
            eb[i] = (m_left[i] > 0);
            el[i] = m_log[i];
            ec[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        end
        chk({tag, ".go"},      32'(go),      32'(eg));
        chk({tag, ".busy"},    32'(busy),    32'(eb));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(ec));
        chk({tag, ".err_any"}, 32'(err_any), 32'(m_any));
`ifdef GOML_ERR_LOG_EN
        chk({tag, ".err_log"}, 32'(err_log), 32'(el));
`endif
    endtask

    task automatic idle_inputs();
        sample = '0; err0 = '0; err1 = '0; rreq = '0; reack = '0;
        cnt_clr = 1'b0; log_clr = 1'b0;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;

        step("idle0");
        step("idle1");

        // Normal path, lane 0
        sample[0] = 1'b1; reack[0] = 1'b1;
        step("norm");
        chk("norm.go0", 32'(go[0]), 32'd1);
        sample[0] = 1'b0; reack[0] = 1'b0;
        step("hold");
        chk("hold.go0", 32'(go[0]), 32'd1);

        // Error path, lane 1
        sample[1] = 1'b1; err1[1] = 1'b1; rreq[1] = 1'b1;
        step("err");
        chk("err.go1",   32'(go[1]),   32'd1);
        chk("err.busy1", 32'(busy[1]), 32'd1);
        chk("err.cnt1",  32'(err_cnt[1*CNT_W +: CNT_W]), 32'd1);
        chk("err.any",   32'(err_any), 32'd1);
        sample[1] = 1'b0; err1[1] = 1'b0;
        step("rec1");
        chk("rec1.busy1", 32'(busy[1]), 32'd1);
        step("rec2");
        chk("rec2.busy1", 32'(busy[1]), 32'd0);

        // Re-error at timer 0, lane 2
        sample[2] = 1'b1; err0[2] = 1'b1;
        step("re_a");
        sample[2] = 1'b0; err0[2] = 1'b0;
        step("re_b");
        sample[2] = 1'b1; err0[2] = 1'b1; err1[2] = 1'b1;
        step("re_c");
        sample[2] = 1'b0; err0[2] = 1'b0; err1[2] = 1'b0;
        chk("re.cnt2", 32'(err_cnt[2*CNT_W +: CNT_W]), 32'd2);
        step("re_d");
        chk("re_d.busy2", 32'(busy[2]), 32'd1);
        step("re_e");
        chk("re_e.busy2", 32'(busy[2]), 32'd0);

        // Saturation, lane 3
        sample[3] = 1'b1; err0[3] = 1'b1;
        for (int k = 0; k < 5; k++) step("sat");
        chk("sat.cnt3", 32'(err_cnt[3*CNT_W +: CNT_W]), 32'd3);
        cnt_clr = 1'b1;
        step("clr");
        chk("clr.cnt3", 32'(err_cnt[3*CNT_W +: CNT_W]), 32'd0);
        idle_inputs();

`ifdef GOML_ERR_LOG_EN
        sample[0] = 1'b1; err1[0] = 1'b1;
        step("log_set");
        chk("log_set.l0", 32'(err_log[0]), 32'd1);
        idle_inputs(); log_clr = 1'b1;
        step("log_clr");
        chk("log_clr.l0", 32'(err_log[0]), 32'd0);
        sample[0] = 1'b1; err0[0] = 1'b1;
        step("log_setclr");
        chk("log_setclr.l0", 32'(err_log[0]), 32'd1);
        idle_inputs();
`endif

        // Async reset in the middle of RECOVER
        sample = '1; err0 = '1; rreq = '1;
        step("pre_rst");
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        idle_inputs();
        #10;
        rst = 1'b0;
        step("post_rst0");
        step("post_rst1");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < LANES; i++) begin
                sample[i] = ($urandom_range(0, 1) == 1);
                err0[i]   = ($urandom_range(0, 4) == 0);
                err1[i]   = ($urandom_range(0, 4) == 0);
                rreq[i]   = ($urandom_range(0, 1) == 1);
                reack[i]  = ($urandom_range(0, 1) == 1);
            end
            cnt_clr = ($urandom_range(0, 15) == 0);
            log_clr = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
